// File: rtl/first_nios2_system_sysid_pkg.sv
// Shared types and constants for the sysid boot checker: FSM states, word addresses, default expectations.
package first_nios2_system_sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ID   = 3'd1,
        ST_WAIT_ID = 3'd2,
        ST_RD_TS   = 3'd3,
        ST_WAIT_TS = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
    localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1363341622;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES     = 255;

endpackage

// File: rtl/first_nios2_system_phase_timer.sv
// Per-phase cycle counter: cleared on entry to a read phase, counts while enabled, saturates at TIMEOUT_CYCLES.
// expired flags the cycle on which the count reaches the limit, so the FSM can leave on that edge.
module first_nios2_system_phase_timer
    import first_nios2_system_sysid_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned     CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

    always_comb begin
        cnt_inc = (cnt_q == LIMIT) ? cnt_q : cnt_q + CW'(1);
        cnt_d   = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_inc;
        end
        expired = enable && (cnt_inc == LIMIT);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// Avalon-MM read master that fetches sysid word 0 (ID) and word 1 (timestamp), compares, and latches a verdict.
// A timeout is sticky until reset because a late response could otherwise be mistaken for a fresh one.
module first_nios2_system_sysid_checker
    import first_nios2_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
    parameter bit          CHECK_TIMESTAMP    = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic        m_readdatavalid,
    input  logic [31:0] m_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    state_e      state_q, state_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        idm_q, idm_d;
    logic        tsm_q, tsm_d;
    logic        timeout_q, timeout_d;
    logic [31:0] cid_q, cid_d;
    logic [31:0] cts_q, cts_d;

    logic        start_ok;
    logic        in_phase;
    logic        timer_clear;
    logic        timer_expired;
    logic        timeout_hit;
    logic        ts_mm_new;

    assign start_ok  = start && !timeout_q;
    assign in_phase  = (state_q == ST_RD_ID) || (state_q == ST_WAIT_ID) ||
                       (state_q == ST_RD_TS) || (state_q == ST_WAIT_TS);
    assign ts_mm_new = (m_readdata != EXPECTED_TIMESTAMP);

    assign timer_clear = ((state_d == ST_RD_ID) && (state_q != ST_RD_ID)) ||
                         ((state_d == ST_RD_TS) && (state_q != ST_RD_TS));

    first_nios2_system_phase_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_phase_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .enable  (in_phase),
        .expired (timer_expired)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Phase completion is tested before expiry so acceptance/response wins a same-edge tie.
    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) state_d = ST_RD_ID;
            end
            ST_RD_ID: begin
                if (!m_waitrequest)     state_d = ST_WAIT_ID;
                else if (timer_expired) timeout_hit = 1'b1;
            end
            ST_WAIT_ID: begin
                if (m_readdatavalid)    state_d = ST_RD_TS;
                else if (timer_expired) timeout_hit = 1'b1;
            end
            ST_RD_TS: begin
                if (!m_waitrequest)     state_d = ST_WAIT_TS;
                else if (timer_expired) timeout_hit = 1'b1;
            end
            ST_WAIT_TS: begin
                if (m_readdatavalid)    state_d = ST_DONE;
                else if (timer_expired) timeout_hit = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (timeout_hit) state_d = ST_DONE;
    end

    always_comb begin
        m_read    = 1'b0;
        m_address = SYSID_ADDR_ID;
        busy      = in_phase;
        case (state_q)
            ST_RD_ID: m_read = 1'b1;
            ST_RD_TS: begin
                m_read    = 1'b1;
                m_address = SYSID_ADDR_TS;
            end
            default: ;
        endcase
    end

    always_comb begin
        done_d    = done_q;
        pass_d    = pass_q;
        idm_d     = idm_q;
        tsm_d     = tsm_q;
        timeout_d = timeout_q;
        cid_d     = cid_q;
        cts_d     = cts_q;
        if (((state_q == ST_IDLE) || (state_q == ST_DONE)) && start_ok) begin
            done_d = 1'b0;
            pass_d = 1'b0;
            idm_d  = 1'b0;
            tsm_d  = 1'b0;
        end
        if ((state_q == ST_WAIT_ID) && m_readdatavalid) begin
            cid_d = m_readdata;
            idm_d = (m_readdata != EXPECTED_ID);
        end
        // Verdict uses the timestamp compare from this same cycle, not the stale register.
        if ((state_q == ST_WAIT_TS) && m_readdatavalid) begin
            cts_d  = m_readdata;
            tsm_d  = ts_mm_new;
            done_d = 1'b1;
            pass_d = !idm_q && !(CHECK_TIMESTAMP && ts_mm_new);
        end
        if (timeout_hit) begin
            timeout_d = 1'b1;
            done_d    = 1'b1;
            pass_d    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            idm_q     <= 1'b0;
            tsm_q     <= 1'b0;
            timeout_q <= 1'b0;
            cid_q     <= '0;
            cts_q     <= '0;
        end else begin
            done_q    <= done_d;
            pass_q    <= pass_d;
            idm_q     <= idm_d;
            tsm_q     <= tsm_d;
            timeout_q <= timeout_d;
            cid_q     <= cid_d;
            cts_q     <= cts_d;
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign id_mismatch = idm_q;
    assign ts_mismatch = tsm_q;
    assign timeout     = timeout_q;
    assign captured_id = cid_q;
    assign captured_ts = cts_q;

endmodule
